// File: rtl/map_scroller.sv
// map_scroller
//   Two-axis scrolling background window. Scroll offsets move once per
//   frame from the current keycode, are shadow-latched when DrawY returns
//   to 0 (so a frame never tears), and every pixel inside the window gets
//   a registered ROM address computed without a multiplier.
//
//   Optional build macro: MAP_SCROLL_WRAP_EN
//     defined   -> horizontal offset wraps modulo MAP_W, and the column
//                  wraps back into the map image
//     undefined -> horizontal offset clamps to MAP_W-WIN_W
//   The vertical offset always clamps to MAP_H-WIN_H.
//
// Ports
//   Clk          system clock (50 MHz)
//   Reset        synchronous, active-high
//   frame_clk    vsync-rate frame clock (edge-detected internally)
//   status       game state; the window shows only at ACTIVE_STATUS
//   keycode      current keycode (KEY_L/KEY_R/KEY_U/KEY_D scroll)
//   DrawX/DrawY  current pixel coordinates
//   is_map       pixel lies inside the map window (1 Clk latency)
//   map_address  ROM address for the pixel (1 Clk latency)
//   scroll_x/y   live scroll offsets
module map_scroller #(
  parameter int          WIN_X0        = 130,
  parameter int          WIN_Y0        = 180,
  parameter int          WIN_W         = 510,
  parameter int          WIN_H         = 120,
  parameter int          MAP_W         = 750,
  parameter int          MAP_H         = 240,
  parameter int          STEP          = 1,
  parameter logic [3:0]  ACTIVE_STATUS = 4'd3,
  parameter logic [7:0]  KEY_L         = 8'h04,
  parameter logic [7:0]  KEY_R         = 8'h07,
  parameter logic [7:0]  KEY_U         = 8'h1A,
  parameter logic [7:0]  KEY_D         = 8'h16,
  parameter int          ADDR_W        = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [3:0]        status,
  input  logic [7:0]        keycode,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              is_map,
  output logic [ADDR_W-1:0] map_address,
  output logic [9:0]        scroll_x,
  output logic [9:0]        scroll_y
);

  localparam logic [9:0] STEP_V  = 10'(STEP);
  localparam logic [9:0] MAX_Y_V = 10'(MAP_H - WIN_H);
`ifdef MAP_SCROLL_WRAP_EN
  // scroll_x >= MAP_W-STEP is exactly the case where a right step wraps
  localparam logic [9:0]  WRAP_BACK = 10'(MAP_W - STEP);
  localparam logic [10:0] MAP_W_COL = 11'(MAP_W);
`else
  localparam logic [9:0] MAX_X_V = 10'(MAP_W - WIN_W);
`endif
  localparam logic [9:0] X_LO = 10'(WIN_X0);
  localparam logic [9:0] X_HI = 10'(WIN_X0 + WIN_W);
  localparam logic [9:0] Y_LO = 10'(WIN_Y0);
  localparam logic [9:0] Y_HI = 10'(WIN_Y0 + WIN_H);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(MAP_W);

  logic              frame_d, fe;
  logic [9:0]        sx_next, sy_next, dy;
  logic              y_down, y_up;
  logic [ADDR_W-1:0] ybase, dy_mul;
  logic [9:0]        prev_y, sx_s;
  logic [ADDR_W-1:0] yb_s, row_base;
  logic              y_changed, in_window;
  logic [10:0]       col_raw, col;

  // d*MAP_W as a constant shift-add: one shifted copy of d per set bit of MAP_W
  function automatic logic [ADDR_W-1:0] times_map_w(input logic [9:0] d);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++)
      if (ROW_PITCH[i]) acc = acc + (ADDR_W'(d) << i);
    return acc;
  endfunction

  // Next scroll offsets. Clamps compare against the remaining headroom so
  // nothing ever underflows; dy is the delta actually applied to scroll_y.
  always_comb begin
    sx_next = scroll_x;
    sy_next = scroll_y;
    dy      = '0;
    y_down  = 1'b0;
    y_up    = 1'b0;
    if (fe) begin
      if (keycode == KEY_R) begin
`ifdef MAP_SCROLL_WRAP_EN
        sx_next = (scroll_x >= WRAP_BACK) ? scroll_x - WRAP_BACK : scroll_x + STEP_V;
`else
        sx_next = ((MAX_X_V - scroll_x) < STEP_V) ? MAX_X_V : scroll_x + STEP_V;
`endif
      end else if (keycode == KEY_L) begin
`ifdef MAP_SCROLL_WRAP_EN
        sx_next = (scroll_x < STEP_V) ? scroll_x + WRAP_BACK : scroll_x - STEP_V;
`else
        sx_next = (scroll_x < STEP_V) ? 10'd0 : scroll_x - STEP_V;
`endif
      end else if (keycode == KEY_D) begin
        dy      = ((MAX_Y_V - scroll_y) < STEP_V) ? (MAX_Y_V - scroll_y) : STEP_V;
        sy_next = scroll_y + dy;
        y_down  = 1'b1;
      end else if (keycode == KEY_U) begin
        dy      = (scroll_y < STEP_V) ? scroll_y : STEP_V;
        sy_next = scroll_y - dy;
        y_up    = 1'b1;
      end
    end
  end

  assign dy_mul = times_map_w(dy);

  // Frame edge detect and live offsets; ybase stays equal to scroll_y*MAP_W
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d  <= 1'b0;
      fe       <= 1'b0;
      scroll_x <= '0;
      scroll_y <= '0;
      ybase    <= '0;
    end else begin
      frame_d  <= frame_clk;
      fe       <= frame_clk & ~frame_d;
      scroll_x <= sx_next;
      scroll_y <= sy_next;
      if (y_down)
        ybase <= ybase + dy_mul;
      else if (y_up)
        ybase <= ybase - dy_mul;
    end
  end

  assign y_changed = (DrawY != prev_y);
  assign in_window = (DrawX >= X_LO) && (DrawX < X_HI) &&
                     (DrawY >= Y_LO) && (DrawY < Y_HI) &&
                     (status == ACTIVE_STATUS);

  // Column inside the map image for the current pixel
  always_comb begin
    col_raw = {1'b0, DrawX - X_LO} + {1'b0, sx_s};
`ifdef MAP_SCROLL_WRAP_EN
    col = (col_raw >= MAP_W_COL) ? col_raw - MAP_W_COL : col_raw;
`else
    col = col_raw;
`endif
  end

  // Shadow latch at frame start, row base stepping, and the output register.
  // On the first Clk of a new row the output still sees the old row_base;
  // the second Clk of the pixel carries the correct address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_y      <= '0;
      sx_s        <= '0;
      yb_s        <= '0;
      row_base    <= '0;
      is_map      <= 1'b0;
      map_address <= '0;
    end else begin
      prev_y <= DrawY;
      if (y_changed && (DrawY == 10'd0)) begin
        sx_s <= scroll_x;
        yb_s <= ybase;
      end
      if (y_changed && (DrawY == Y_LO))
        row_base <= yb_s;
      else if (y_changed && (DrawY > Y_LO) && (DrawY < Y_HI))
        row_base <= row_base + ROW_PITCH;
      if (in_window) begin
        is_map      <= 1'b1;
        map_address <= row_base + ADDR_W'(col);
      end else begin
        is_map      <= 1'b0;
        map_address <= '0;
      end
    end
  end

endmodule

// File: tb/tb_map_scroller.sv
// tb_map_scroller
//   Self-checking bench for map_scroller at default parameters. A model
//   tracks the offsets and frame-start shadows with plain integer
//   arithmetic and predicts every pixel's address as
//   (shadow_y + row)*MAP_W + column. Pixels last 2 Clk; the model result
//   is compared on the second Clk of each pixel. A few literal values pin
//   the model. Build with +define+MAP_SCROLL_WRAP_EN for the wrap variant.
`timescale 1ns/1ps
module tb_map_scroller;

  localparam int WIN_X0 = 130;
  localparam int WIN_Y0 = 180;
  localparam int WIN_W  = 510;
  localparam int WIN_H  = 120;
  localparam int MAP_W  = 750;
  localparam int MAP_H  = 240;
  localparam int STEP   = 1;
  localparam int ADDR_W = 20;
  localparam int MAX_X  = MAP_W - WIN_W;
  localparam int MAX_Y  = MAP_H - WIN_H;
  localparam logic [7:0] KEY_L = 8'h04;
  localparam logic [7:0] KEY_R = 8'h07;
  localparam logic [7:0] KEY_U = 8'h1A;
  localparam logic [7:0] KEY_D = 8'h16;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              frame_clk = 1'b0;
  logic [3:0]        status = 4'd3;
  logic [7:0]        keycode = 8'h00;
  logic [9:0]        DrawX = '0;
  logic [9:0]        DrawY = '0;
  logic              is_map;
  logic [ADDR_W-1:0] map_address;
  logic [9:0]        scroll_x, scroll_y;

  map_scroller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .status(status),
    .keycode(keycode), .DrawX(DrawX), .DrawY(DrawY), .is_map(is_map),
    .map_address(map_address), .scroll_x(scroll_x), .scroll_y(scroll_y)
  );

  always #10 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // model state: live offsets, frame-start shadows, last driven DrawY
  int m_sx = 0, m_sy = 0, m_sxs = 0, m_sys = 0, last_y = 0;
  logic              check_pending = 1'b0;
  logic              exp_is_map = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;

  function automatic void modelKey(input logic [7:0] k);
    if (k == KEY_R) begin
`ifdef MAP_SCROLL_WRAP_EN
      m_sx = (m_sx + STEP) % MAP_W;
`else
      m_sx = (m_sx + STEP > MAX_X) ? MAX_X : m_sx + STEP;
`endif
    end else if (k == KEY_L) begin
`ifdef MAP_SCROLL_WRAP_EN
      m_sx = (m_sx - STEP + MAP_W) % MAP_W;
`else
      m_sx = (m_sx - STEP < 0) ? 0 : m_sx - STEP;
`endif
    end else if (k == KEY_D) begin
      m_sy = (m_sy + STEP > MAX_Y) ? MAX_Y : m_sy + STEP;
    end else if (k == KEY_U) begin
      m_sy = (m_sy - STEP < 0) ? 0 : m_sy - STEP;
    end
  endfunction

  function automatic void modelPixel(input int x, input int y);
    int col;
    exp_is_map = (x >= WIN_X0) && (x < WIN_X0 + WIN_W) &&
                 (y >= WIN_Y0) && (y < WIN_Y0 + WIN_H) && (status == 4'd3);
    if (exp_is_map) begin
      col = x - WIN_X0 + m_sxs;
`ifdef MAP_SCROLL_WRAP_EN
      col = col % MAP_W;
`endif
      exp_addr = ADDR_W'((m_sys + y - WIN_Y0) * MAP_W + col);
    end else begin
      exp_addr = '0;
    end
  endfunction

  // Checks the pixel presented by applyStimulus on its second Clk
  always @(negedge Clk) begin
    if (check_pending) begin
      vectors++;
      if (is_map !== exp_is_map || map_address !== exp_addr ||
          scroll_x !== 10'(m_sx) || scroll_y !== 10'(m_sy)) begin
        miscompares++;
        $display("[TB] FAIL pixel(%0d,%0d): got is_map=%0b addr=%0d sx=%0d sy=%0d, required is_map=%0b addr=%0d sx=%0d sy=%0d",
                 DrawX, DrawY, is_map, map_address, scroll_x, scroll_y,
                 exp_is_map, exp_addr, m_sx, m_sy);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    check_pending = 1'b0;
  endtask

  // Present one pixel for 2 Clk; the compare process checks it afterwards
  task automatic applyStimulus(input int x, input int y);
    tick();
    if (y != last_y && y == 0) begin
      m_sxs = m_sx;
      m_sys = m_sy;
    end
    last_y = y;
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    modelPixel(x, y);
    repeat (2) @(posedge Clk);
    #1;
    check_pending = 1'b1;
  endtask

  task automatic frameEdges(input logic [7:0] k, input int n);
    tick();
    keycode = k;
    repeat (n) begin
      frame_clk = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      frame_clk = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      modelKey(k);
    end
    keycode = 8'h00;
  endtask

  task automatic setStatus(input logic [3:0] s);
    tick();
    status = s;
  endtask

  task automatic doReset();
    tick();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    m_sx = 0; m_sy = 0; m_sxs = 0; m_sys = 0;
  endtask

  function automatic int randX();
    int r;
    r = int'($urandom_range(0, 7));
    case (r)
      0: return WIN_X0 - 1;
      1: return WIN_X0;
      2: return WIN_X0 + WIN_W - 1;
      3: return WIN_X0 + WIN_W;
      default: return int'($urandom_range(0, 799));
    endcase
  endfunction

  task automatic walk(input int from, input int to);
    for (int y = from; y <= to; y++) applyStimulus(randX(), y);
  endtask

  task automatic scanFrame(input int npx);
    applyStimulus(randX(), 0);
    applyStimulus(randX(), 1);
    applyStimulus(randX(), WIN_Y0 - 1);
    for (int y = WIN_Y0; y < WIN_Y0 + WIN_H; y++)
      repeat (npx) applyStimulus(randX(), y);
    applyStimulus(randX(), WIN_Y0 + WIN_H);
    applyStimulus(randX(), 479);
  endtask

  initial begin
    $display("[TB] map_scroller bench start");
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    checkOutput("reset is_map", int'(is_map), 0);
    checkOutput("reset map_address", int'(map_address), 0);
    checkOutput("reset scroll_x", int'(scroll_x), 0);
    checkOutput("reset scroll_y", int'(scroll_y), 0);

    applyStimulus(130, 180);
    checkOutput("first pixel is_map", int'(is_map), 1);
    checkOutput("first pixel address", int'(map_address), 0);
    applyStimulus(640, 180);
    checkOutput("right edge is_map", int'(is_map), 0);
    checkOutput("right edge address", int'(map_address), 0);

`ifndef MAP_SCROLL_WRAP_EN
    frameEdges(KEY_L, 3);
    checkOutput("left clamp at 0", int'(scroll_x), 0);

    frameEdges(KEY_R, 300);
    checkOutput("right clamp 240", int'(scroll_x), 240);
    applyStimulus(0, 479);
    applyStimulus(0, 0);
    applyStimulus(130, 180);
    checkOutput("scrolled first pixel", int'(map_address), 240);
    walk(181, 298);
    // 119*750 + 509 + 240 = 89999
    applyStimulus(639, 299);
    checkOutput("scrolled last pixel", int'(map_address), 89999);

    frameEdges(KEY_L, 300);
    checkOutput("left back to 0", int'(scroll_x), 0);
    applyStimulus(0, 479);
    applyStimulus(0, 0);
    frameEdges(KEY_D, 5);
    checkOutput("scroll_y 5", int'(scroll_y), 5);
    checkOutput("ybase 3750", int'(dut.ybase), 3750);
    applyStimulus(130, 180);
    checkOutput("same frame unchanged", int'(map_address), 0);
    applyStimulus(0, 479);
    applyStimulus(0, 0);
    applyStimulus(130, 180);
    checkOutput("next frame y-scrolled", int'(map_address), 3750);
    applyStimulus(131, 181);
    checkOutput("second row pixel", int'(map_address), 4501);

    walk(182, 200);
    frameEdges(KEY_R, 20);
    applyStimulus(130, 201);
    checkOutput("mid-frame change hidden", int'(map_address), 19500);
    walk(202, 299);
    applyStimulus(0, 479);
    applyStimulus(0, 0);
    applyStimulus(130, 180);
    checkOutput("mid-frame change visible", int'(map_address), 3770);

    setStatus(4'd2);
    applyStimulus(300, 181);
    checkOutput("inactive status is_map", int'(is_map), 0);
    setStatus(4'd3);
    checkOutput("offsets kept x", int'(scroll_x), 20);
    checkOutput("offsets kept y", int'(scroll_y), 5);
    applyStimulus(300, 182);
    checkOutput("reactivated address", int'(map_address), 5440);
    walk(183, 299);
`endif

    applyStimulus(randX(), 0);
    walk(180, 200);
    frameEdges(KEY_D, 3);
    doReset();
    checkOutput("mid-frame reset scroll_x", int'(scroll_x), 0);
    checkOutput("mid-frame reset scroll_y", int'(scroll_y), 0);
    checkOutput("mid-frame reset address", int'(map_address), 0);
    scanFrame(2);

`ifdef MAP_SCROLL_WRAP_EN
    doReset();
    frameEdges(KEY_L, 1);
    checkOutput("wrap left from 0", int'(scroll_x), 749);
    frameEdges(KEY_R, 1);
    checkOutput("wrap right from 749", int'(scroll_x), 0);
    frameEdges(KEY_L, 50);
    checkOutput("wrap to 700", int'(scroll_x), 700);
    applyStimulus(0, 0);
    applyStimulus(180, 180);
    checkOutput("column wrap address", int'(map_address), 0);
    applyStimulus(0, 479);
`endif

    for (int f = 0; f < 16; f++) begin
      logic [7:0] k;
      case ($urandom_range(0, 5))
        0: k = KEY_L;
        1: k = KEY_R;
        2: k = KEY_U;
        3: k = KEY_D;
        4: k = 8'h55;
        default: k = 8'h00;
      endcase
      setStatus(($urandom_range(0, 4) == 0) ? 4'd2 : 4'd3);
      frameEdges(k, int'($urandom_range(0, 40)));
      scanFrame(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
